// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU microsequencer: instruction layout, FSM states and
// the datapath's ALU select encoding.
package alu_seq_pkg;

    localparam int unsigned INSTR_W = 12;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned IMM_W   = 4;

    // ALU select codes as decoded by the downstream datapath
    localparam logic [SEL_W-1:0] SEL_ADD    = 3'd0;
    localparam logic [SEL_W-1:0] SEL_SUB    = 3'd1;
    localparam logic [SEL_W-1:0] SEL_AND    = 3'd2;
    localparam logic [SEL_W-1:0] SEL_OR     = 3'd3;
    localparam logic [SEL_W-1:0] SEL_XOR    = 3'd4;
    localparam logic [SEL_W-1:0] SEL_NOT    = 3'd5;
    localparam logic [SEL_W-1:0] SEL_PASS_B = 3'd6;
    localparam logic [SEL_W-1:0] SEL_PASS_A = 3'd7;

    typedef enum logic [1:0] {
        OP_EXEC = 2'b00,
        OP_JMP  = 2'b01,
        OP_JC   = 2'b10,
        OP_HALT = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_EXEC   = 2'd2,
        S_HALTED = 2'd3
    } state_e;

    // Field positions: [11:10] op, [9:7] sel, [6] src, [5] dst, [4] we, [3:0] imm
    typedef struct packed {
        op_e              op;
        logic [SEL_W-1:0] sel;
        logic             src;
        logic             dst;
        logic             we;
        logic [IMM_W-1:0] imm;
    } instr_t;

endpackage

// File: rtl/alu_microsequencer_decoder.sv
// Combinational decode of the held instruction into datapath enables, ALU
// select and B operand; everything is inactive/zero outside the EXEC state.
module instr_decoder
    import alu_seq_pkg::*;
(
    input  logic [INSTR_W-1:0] ir_word,
    input  logic               exec,
    output logic               eibar1_c,
    output logic               eibar2_c,
    output logic               eobar1_c,
    output logic               eobar2_c,
    output logic [SEL_W-1:0]   sel_c,
    output logic [IMM_W-1:0]   b_c
);

    instr_t ir;
    assign ir = instr_t'(ir_word);

    // Exactly one bus driver per EXEC; a write enable only when we is set
    always_comb begin
        eibar1_c = 1'b1;
        eibar2_c = 1'b1;
        eobar1_c = 1'b1;
        eobar2_c = 1'b1;
        sel_c    = '0;
        b_c      = '0;
        if (exec && ir.op == OP_EXEC) begin
            eobar1_c = ir.src;
            eobar2_c = ~ir.src;
            eibar1_c = ~(ir.we & ~ir.dst);
            eibar2_c = ~(ir.we & ir.dst);
            sel_c    = ir.sel;
            b_c      = ir.imm;
        end
    end

endmodule

// File: rtl/alu_microsequencer.sv
// Program store and fetch/execute sequencer driving the two-register ALU
// datapath, with carry-conditional jumps and a runaway-step abort.
module alu_microsequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned MAX_STEPS = 255
) (
    input  logic                     clk,
    input  logic                     MRbar,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [INSTR_W-1:0]       prog_data,
    input  logic                     start,
    input  logic                     carry_in,
    output logic                     EIbar1,
    output logic                     EIbar2,
    output logic                     EObar1,
    output logic                     EObar2,
    output logic [SEL_W-1:0]         sel,
    output logic [IMM_W-1:0]         B,
    output logic [$clog2(DEPTH)-1:0] pc,
    output logic                     busy,
    output logic                     done,
    output logic                     abort
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned SW = $clog2(MAX_STEPS + 1);

    logic [INSTR_W-1:0] mem [DEPTH];
    state_e             state;
    instr_t             ir;
    logic               carry_flag;
    logic [SW-1:0]      step_cnt;
    logic [PW-1:0]      pc_inc;
    logic [PW-1:0]      target;

    assign pc_inc = pc + 1'b1;
    assign target = PW'(ir.imm);

    // Program store: writable only while idle, never reset
    always_ff @(posedge clk) begin
        if (prog_we && state == S_IDLE) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk or negedge MRbar) begin
        if (!MRbar) begin
            state      <= S_IDLE;
            ir         <= '0;
            pc         <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            abort      <= 1'b0;
            carry_flag <= 1'b0;
            step_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_FETCH;
                        busy       <= 1'b1;
                        pc         <= '0;
                        step_cnt   <= '0;
                        carry_flag <= 1'b0;
                        abort      <= 1'b0;
                    end
                end
                S_FETCH: begin
                    ir    <= instr_t'(mem[pc]);
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (ir.op == OP_HALT) begin
                        state <= S_HALTED;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        case (ir.op)
                            OP_EXEC: begin
                                carry_flag <= carry_in;
                                pc         <= pc_inc;
                            end
                            OP_JMP:  pc <= target;
                            OP_JC:   pc <= carry_flag ? target : pc_inc;
                            default: pc <= pc;
                        endcase
                        step_cnt <= step_cnt + 1'b1;
                        // The instruction that exhausts the budget still takes effect
                        if (step_cnt == SW'(MAX_STEPS - 1)) begin
                            state <= S_HALTED;
                            busy  <= 1'b0;
                            abort <= 1'b1;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_HALTED: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    instr_decoder u_decoder (
        .ir_word  (INSTR_W'(ir)),
        .exec     (state == S_EXEC),
        .eibar1_c (EIbar1),
        .eibar2_c (EIbar2),
        .eobar1_c (EObar1),
        .eobar2_c (EObar2),
        .sel_c    (sel),
        .b_c      (B)
    );

endmodule

// File: tb/tb_alu_microsequencer.sv
// Self-checking bench: instruction-level reference model of program execution
// compared cycle by cycle against the sequencer's outputs.
module tb_alu_microsequencer;
    import alu_seq_pkg::*;

    localparam int unsigned DEPTH     = 16;
    localparam int unsigned MAX_STEPS = 20;

    logic        clk = 1'b0;
    logic        MRbar, prog_we, start, carry_in;
    logic [3:0]  prog_addr;
    logic [11:0] prog_data;
    logic        EIbar1, EIbar2, EObar1, EObar2;
    logic [2:0]  sel;
    logic [3:0]  B;
    logic [3:0]  pc;
    logic        busy, done, abort;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    alu_microsequencer #(.DEPTH(DEPTH), .MAX_STEPS(MAX_STEPS)) dut (
        .clk(clk), .MRbar(MRbar), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .carry_in(carry_in),
        .EIbar1(EIbar1), .EIbar2(EIbar2), .EObar1(EObar1), .EObar2(EObar2),
        .sel(sel), .B(B), .pc(pc), .busy(busy), .done(done), .abort(abort)
    );

    function automatic logic [11:0] mk(logic [1:0] t, logic [2:0] s, logic src,
                                       logic dst, logic we, logic [3:0] imm);
        return {t, s, src, dst, we, imm};
    endfunction

    // Expected output vector {EIbar1,EIbar2,EObar1,EObar2,sel,B,pc,busy,done,abort}
    function automatic logic [17:0] ev(logic [3:0] en, logic [2:0] s, logic [3:0] b,
                                       logic [3:0] p, logic bz, logic dn, logic ab);
        return {en, s, b, p, bz, dn, ab};
    endfunction

    // Datapath controls expected while an instruction word is executing
    function automatic logic [17:0] exec_exp(logic [11:0] w, logic [3:0] p);
        logic ei1, ei2, eo1, eo2;
        logic [2:0] s;
        logic [3:0] b;
        ei1 = 1'b1; ei2 = 1'b1; eo1 = 1'b1; eo2 = 1'b1; s = 3'd0; b = 4'd0;
        if (w[11:10] == 2'b00) begin
            if (w[6]) eo2 = 1'b0; else eo1 = 1'b0;
            if (w[4]) begin
                if (w[5]) ei2 = 1'b0; else ei1 = 1'b0;
            end
            s = w[9:7];
            b = w[3:0];
        end
        return ev({ei1, ei2, eo1, eo2}, s, b, p, 1'b1, 1'b0, 1'b0);
    endfunction

    task automatic check(input string tag, input logic [17:0] exp_v);
        logic [17:0] obs_v;
        obs_v = {EIbar1, EIbar2, EObar1, EObar2, sel, B, pc, busy, done, abort};
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs_v, exp_v);
        end
    endtask

    task automatic check_val(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic write_word(input logic [3:0] a, input logic [11:0] d);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(negedge clk);
        prog_we = 1'b0;
        model_mem[a] = d;
    endtask

    // cmode: 0 carry low, 1 carry high, 2 random; poke: prog_we/start while busy
    task automatic run_program(input string tag, input int cmode, input bit poke,
                               input bit wr0, input logic [11:0] wr0_data);
        logic [3:0]  mpc;
        logic        mcarry, aborted;
        logic [11:0] w;
        int          steps, cyc;
        bit          fin;
        mpc = 4'd0; mcarry = 1'b0; aborted = 1'b0; steps = 0; cyc = 0; fin = 1'b0;
        @(negedge clk);
        start = 1'b1;
        if (wr0) begin
            prog_we = 1'b1; prog_addr = 4'd0; prog_data = wr0_data;
            model_mem[0] = wr0_data;
        end
        @(negedge clk);
        start = 1'b0; prog_we = 1'b0;
        while (!fin && cyc < 100) begin
            check({tag, "/fetch"}, ev(4'hF, 3'd0, 4'd0, mpc, 1'b1, 1'b0, 1'b0));
            if (poke) begin
                prog_we = 1'b1; prog_addr = mpc + 4'd1; prog_data = 12'hC00; start = 1'b1;
            end
            @(negedge clk);
            prog_we = 1'b0; start = 1'b0;
            w = model_mem[mpc];
            check({tag, "/exec"}, exec_exp(w, mpc));
            carry_in = (cmode == 2) ? 1'($urandom_range(0, 1)) : 1'(cmode);
            if (poke) begin
                prog_we = 1'b1; prog_addr = mpc; prog_data = 12'hC00; start = 1'b1;
            end
            @(negedge clk);
            prog_we = 1'b0; start = 1'b0;
            case (w[11:10])
                2'b00: begin mcarry = carry_in; mpc = mpc + 4'd1; end
                2'b01: mpc = w[3:0];
                2'b10: mpc = mcarry ? w[3:0] : mpc + 4'd1;
                default: ;
            endcase
            if (w[11:10] == 2'b11) begin
                fin = 1'b1;
                check({tag, "/halted"}, ev(4'hF, 3'd0, 4'd0, mpc, 1'b0, 1'b1, 1'b0));
            end else begin
                steps++;
                if (steps == MAX_STEPS) begin
                    fin = 1'b1; aborted = 1'b1;
                    check({tag, "/aborted"}, ev(4'hF, 3'd0, 4'd0, mpc, 1'b0, 1'b0, 1'b1));
                end
            end
            cyc++;
        end
        check_val({tag, "/finished"}, int'(fin), 1);
        @(negedge clk);
        check({tag, "/idle"}, ev(4'hF, 3'd0, 4'd0, mpc, 1'b0, 1'b0, aborted));
    endtask

    initial begin
        MRbar = 1'b0; prog_we = 1'b0; start = 1'b0; carry_in = 1'b0;
        prog_addr = 4'd0; prog_data = 12'd0;
        #12;
        check("reset", ev(4'hF, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        MRbar = 1'b1;

        // Basic EXEC then HALT
        write_word(4'd0, mk(OP_EXEC, SEL_ADD, 1'b0, 1'b1, 1'b1, 4'b0101));
        write_word(4'd1, mk(OP_HALT, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0));
        run_program("basic", 0, 1'b0, 1'b0, 12'd0);

        // Conditional jump taken and not taken
        write_word(4'd0, mk(OP_EXEC, SEL_SUB, 1'b1, 1'b0, 1'b0, 4'd7));
        write_word(4'd1, mk(OP_JC, 3'd0, 1'b0, 1'b0, 1'b0, 4'b0011));
        write_word(4'd2, mk(OP_HALT, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0));
        write_word(4'd3, mk(OP_HALT, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0));
        run_program("jc_taken", 1, 1'b0, 1'b0, 12'd0);
        run_program("jc_not_taken", 0, 1'b0, 1'b0, 12'd0);

        // All EXEC: pc wraps 15->0, writes/starts while busy ignored, ends in abort
        for (int i = 0; i < 16; i++) begin
            write_word(4'(i), mk(OP_EXEC, 3'(i), 1'(i), 1'(i >> 1), 1'b1, 4'(15 - i)));
        end
        run_program("wrap_poke", 2, 1'b1, 1'b0, 12'd0);

        // Tight JMP loop aborts on the step limit
        write_word(4'd0, mk(OP_JMP, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0));
        run_program("jmp_abort", 0, 1'b0, 1'b0, 12'd0);

        // Write to address 0 together with start: run sees the new word, abort clears
        run_program("start_with_write", 0, 1'b0, 1'b1, mk(OP_HALT, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0));

        // Random programs with random carries
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) begin
                write_word(4'(i), 12'($urandom));
            end
            run_program("random", 2, 1'b0, 1'b0, 12'd0);
        end

        // Asynchronous reset in the middle of a writing EXEC
        write_word(4'd0, mk(OP_EXEC, SEL_OR, 1'b0, 1'b1, 1'b1, 4'd9));
        write_word(4'd1, mk(OP_HALT, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0));
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        check("pre_reset_exec", exec_exp(model_mem[0], 4'd0));
        #1 MRbar = 1'b0;
        #1 check("async_reset", ev(4'hF, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        check("held_reset", ev(4'hF, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
        MRbar = 1'b1;
        @(negedge clk);
        check("after_reset", ev(4'hF, 3'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
        run_program("post_reset", 1, 1'b0, 1'b0, 12'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
